// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the Frogger game sequencer: FSM state codes,
// move-direction codes, the BCD digit type, and two small helpers used by the
// controller (press arbitration and the lives-to-LED thermometer mapping).
// -----------------------------------------------------------------------------
package frogger_pkg;

   // State codes are visible on o_State, so they are fixed numeric constants.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PLAY      = 3'd1;
   localparam logic [2:0] ST_DYING     = 3'd2;
   localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
   localparam logic [2:0] ST_GAME_OVER = 3'd4;

   // Direction codes match the bit positions of the button bus {R,L,D,U}.
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } move_dir_t;

   typedef logic [3:0] bcd_digit_t;

   // Simultaneous presses resolve Up > Down > Left > Right.
   function automatic move_dir_t arbitrate_press(input logic [3:0] press);
      move_dir_t dir;
      if (press[0])
         dir = DIR_UP;
      else if (press[1])
         dir = DIR_DOWN;
      else if (press[2])
         dir = DIR_LEFT;
      else
         dir = DIR_RIGHT;
      return dir;
   endfunction

   function automatic logic [2:0] lives_to_therm(input logic [1:0] lives);
      logic [2:0] therm;
      case (lives)
         2'd0:    therm = 3'b000;
         2'd1:    therm = 3'b001;
         2'd2:    therm = 3'b011;
         default: therm = 3'b111;
      endcase
      return therm;
   endfunction

endpackage

// File: rtl/frogger_frame_tick.sv
// -----------------------------------------------------------------------------
// frogger_frame_tick
// Produces a one-cycle frame tick on the falling edge of VSync (end of the
// active rows). All game timing is counted in these ticks.
//
// Ports:
//   i_Clk    in   system/pixel clock
//   i_Rst    in   synchronous reset, active-high
//   i_VSync  in   VSync level from the VGA sync generator
//   o_Tick   out  1 for one cycle when VSync goes 1 -> 0
// -----------------------------------------------------------------------------
module frogger_frame_tick (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_VSync,
   output logic o_Tick
);

   logic vsync_reg;

   always_ff @(posedge i_Clk) begin
      if (i_Rst)
         vsync_reg <= 1'b0;
      else
         vsync_reg <= i_VSync;
   end

   assign o_Tick = vsync_reg & ~i_VSync;

endmodule

// File: rtl/frogger_game_ctrl.sv
// -----------------------------------------------------------------------------
// frogger_game_ctrl
// Game-level sequencer for Frogger. Converts debounced switch levels into
// one-shot move requests (valid/ready), detects the four-switch start chord,
// and sequences IDLE / PLAY / DYING / LEVEL_UP / GAME_OVER. Owns lives, level
// and the two-digit BCD score.
//
// Ports:
//   i_Clk           in   system/pixel clock
//   i_Rst           in   synchronous reset, active-high
//   i_VSync         in   VSync (frame timing source)
//   i_Buttons[3:0]  in   debounced switches {Right,Left,Down,Up}
//   i_Hit           in   collision from datapath
//   i_Goal          in   frog reached home row
//   i_Move_Ready    in   datapath accepts the pending move this cycle
//   o_Move_Valid    out  move request pending
//   o_Move_Dir[1:0] out  0=Up 1=Down 2=Left 3=Right
//   o_Frog_Respawn  out  one-cycle pulse when the state becomes PLAY
//   o_Freeze        out  halt object motion (every state but PLAY)
//   o_State[2:0]    out  current state code
//   o_Lives[2:0]    out  thermometer-coded lives for the LEDs
//   o_Level[2:0]    out  current level
//   o_Score_Tens    out  BCD tens digit
//   o_Score_Ones    out  BCD ones digit
// -----------------------------------------------------------------------------
module frogger_game_ctrl
   import frogger_pkg::*;
#(
   parameter int unsigned START_HOLD_FRAMES = 30,
   parameter int unsigned DEATH_FRAMES      = 60,
   parameter int unsigned LEVEL_FRAMES      = 90,
   parameter int unsigned INIT_LIVES        = 3,
   parameter int unsigned MAX_LEVEL         = 7
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_VSync,
   input  logic [3:0] i_Buttons,
   input  logic       i_Hit,
   input  logic       i_Goal,
   input  logic       i_Move_Ready,
   output logic       o_Move_Valid,
   output logic [1:0] o_Move_Dir,
   output logic       o_Frog_Respawn,
   output logic       o_Freeze,
   output logic [2:0] o_State,
   output logic [2:0] o_Lives,
   output logic [2:0] o_Level,
   output logic [3:0] o_Score_Tens,
   output logic [3:0] o_Score_Ones
);

   localparam logic [6:0] HOLD_CNT   = 7'(START_HOLD_FRAMES);
   localparam logic [6:0] DEATH_CNT  = 7'(DEATH_FRAMES);
   localparam logic [6:0] LEVEL_CNT  = 7'(LEVEL_FRAMES);
   localparam logic [1:0] LIVES_INIT = 2'(INIT_LIVES);
   localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

   logic       tick;
   logic [3:0] btn_reg;
   logic [3:0] press;

   logic [2:0] state_reg, state_next;
   logic [6:0] frame_cnt_reg, frame_cnt_next;
   logic [6:0] frame_cnt_inc;
   logic       move_valid_reg, move_valid_next;
   move_dir_t  move_dir_reg, move_dir_next;
   logic       respawn_reg, respawn_next;
   logic [1:0] lives_reg, lives_next;
   logic [2:0] level_reg, level_next;
   bcd_digit_t tens_reg, tens_next;
   bcd_digit_t ones_reg, ones_next;

   frogger_frame_tick u_frame_tick (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_VSync (i_VSync),
      .o_Tick  (tick)
   );

   assign press         = i_Buttons & ~btn_reg;
   assign frame_cnt_inc = frame_cnt_reg + 7'd1;

   always_comb begin
      state_next      = state_reg;
      frame_cnt_next  = frame_cnt_reg;
      move_valid_next = move_valid_reg;
      move_dir_next   = move_dir_reg;
      respawn_next    = 1'b0;
      lives_next      = lives_reg;
      level_next      = level_reg;
      tens_next       = tens_reg;
      ones_next       = ones_reg;

      case (state_reg)
         ST_IDLE, ST_GAME_OVER: begin
            // The frame counter doubles as the start-chord hold counter here.
            if (tick) begin
               if (i_Buttons == 4'hF) begin
                  if (frame_cnt_inc == HOLD_CNT) begin
                     state_next     = ST_PLAY;
                     frame_cnt_next = 7'd0;
                     respawn_next   = 1'b1;
                     lives_next     = LIVES_INIT;
                     level_next     = 3'd1;
                     tens_next      = 4'd0;
                     ones_next      = 4'd0;
                  end else begin
                     frame_cnt_next = frame_cnt_inc;
                  end
               end else begin
                  frame_cnt_next = 7'd0;
               end
            end
         end

         ST_PLAY: begin
            if (i_Hit) begin
               state_next      = ST_DYING;
               frame_cnt_next  = 7'd0;
               move_valid_next = 1'b0;
               if (lives_reg != 2'd0)
                  lives_next = lives_reg - 2'd1;
            end else if (i_Goal) begin
               state_next      = ST_LEVEL_UP;
               frame_cnt_next  = 7'd0;
               move_valid_next = 1'b0;
               if (level_reg < LEVEL_MAX)
                  level_next = level_reg + 3'd1;
               // 99 is the ceiling; otherwise ones 9 -> 0 carries into tens.
               if (!(tens_reg == 4'd9 && ones_reg == 4'd9)) begin
                  if (ones_reg == 4'd9) begin
                     ones_next = 4'd0;
                     tens_next = tens_reg + 4'd1;
                  end else begin
                     ones_next = ones_reg + 4'd1;
                  end
               end
            end else if (move_valid_reg) begin
               // Presses seen while a request is outstanding (including the
               // acceptance cycle) are dropped.
               if (i_Move_Ready)
                  move_valid_next = 1'b0;
            end else if (press != 4'd0) begin
               move_valid_next = 1'b1;
               move_dir_next   = arbitrate_press(press);
            end
         end

         ST_DYING: begin
            if (tick) begin
               if (frame_cnt_inc == DEATH_CNT) begin
                  frame_cnt_next = 7'd0;
                  if (lives_reg == 2'd0) begin
                     state_next = ST_GAME_OVER;
                  end else begin
                     state_next   = ST_PLAY;
                     respawn_next = 1'b1;
                  end
               end else begin
                  frame_cnt_next = frame_cnt_inc;
               end
            end
         end

         ST_LEVEL_UP: begin
            if (tick) begin
               if (frame_cnt_inc == LEVEL_CNT) begin
                  frame_cnt_next = 7'd0;
                  state_next     = ST_PLAY;
                  respawn_next   = 1'b1;
               end else begin
                  frame_cnt_next = frame_cnt_inc;
               end
            end
         end

         default: begin
            state_next     = ST_IDLE;
            frame_cnt_next = 7'd0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         btn_reg        <= 4'd0;
         state_reg      <= ST_IDLE;
         frame_cnt_reg  <= 7'd0;
         move_valid_reg <= 1'b0;
         move_dir_reg   <= DIR_UP;
         respawn_reg    <= 1'b0;
         lives_reg      <= 2'd0;
         level_reg      <= 3'd0;
         tens_reg       <= 4'd0;
         ones_reg       <= 4'd0;
      end else begin
         btn_reg        <= i_Buttons;
         state_reg      <= state_next;
         frame_cnt_reg  <= frame_cnt_next;
         move_valid_reg <= move_valid_next;
         move_dir_reg   <= move_dir_next;
         respawn_reg    <= respawn_next;
         lives_reg      <= lives_next;
         level_reg      <= level_next;
         tens_reg       <= tens_next;
         ones_reg       <= ones_next;
      end
   end

   assign o_Move_Valid   = move_valid_reg;
   assign o_Move_Dir     = move_dir_reg;
   assign o_Frog_Respawn = respawn_reg;
   assign o_Freeze       = (state_reg != ST_PLAY);
   assign o_State        = state_reg;
   assign o_Lives        = lives_to_therm(lives_reg);
   assign o_Level        = level_reg;
   assign o_Score_Tens   = tens_reg;
   assign o_Score_Ones   = ones_reg;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frogger_game_ctrl
// Randomized bench for frogger_game_ctrl. An event-level reference model
// (integer score, lives count, outstanding-move queue) predicts every state
// entry and every accepted move; a monitor on the falling clock edge pops and
// compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_frogger_game_ctrl;

   localparam int START_HOLD = 30;
   localparam int DEATH_F    = 60;
   localparam int LEVEL_F    = 90;
   localparam int INIT_L     = 3;
   localparam int MAX_L      = 7;

   logic       clk = 1'b0;
   logic       rst;
   logic       vsync;
   logic [3:0] btn;
   logic       hit;
   logic       goal;
   logic       ready;

   logic       o_move_valid;
   logic [1:0] o_move_dir;
   logic       o_respawn;
   logic       o_freeze;
   logic [2:0] o_state;
   logic [2:0] o_lives;
   logic [2:0] o_level;
   logic [3:0] o_tens;
   logic [3:0] o_ones;

   always #5 clk = ~clk;

   frogger_game_ctrl #(
      .START_HOLD_FRAMES (START_HOLD),
      .DEATH_FRAMES      (DEATH_F),
      .LEVEL_FRAMES      (LEVEL_F),
      .INIT_LIVES        (INIT_L),
      .MAX_LEVEL         (MAX_L)
   ) dut (
      .i_Clk          (clk),
      .i_Rst          (rst),
      .i_VSync        (vsync),
      .i_Buttons      (btn),
      .i_Hit          (hit),
      .i_Goal         (goal),
      .i_Move_Ready   (ready),
      .o_Move_Valid   (o_move_valid),
      .o_Move_Dir     (o_move_dir),
      .o_Frog_Respawn (o_respawn),
      .o_Freeze       (o_freeze),
      .o_State        (o_state),
      .o_Lives        (o_lives),
      .o_Level        (o_level),
      .o_Score_Tens   (o_tens),
      .o_Score_Ones   (o_ones)
   );

   typedef struct {
      int     state;
      int     lives;
      int     level;
      int     score;
      longint t;
   } entry_t;

   entry_t exp_q[$];
   int     move_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int         m_state = 0;
   int         m_lives = 0;
   int         m_level = 0;
   int         m_score = 0;
   int         m_cnt   = 0;
   int         m_ticks = 0;
   bit         m_valid = 1'b0;
   bit         m_vs_prev = 1'b0;
   logic [3:0] m_btn_prev = 4'd0;
   int         cyc = 0;

   bit         mon_en = 1'b0;
   logic [2:0] prev_state = 3'd0;
   logic       prev_valid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_dir(input logic [3:0] p);
      for (int i = 0; i < 4; i++)
         if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_enter(input int s);
      entry_t e;
      if (s != m_state) begin
         e.state = s;
         e.lives = m_lives;
         e.level = m_level;
         e.score = m_score;
         e.t     = $time;
         exp_q.push_back(e);
      end
      m_state = s;
      m_cnt   = 0;
   endtask

   // Advance the model by one clock using the inputs sampled at this edge.
   task automatic model_step();
      bit         tck;
      bit         was_valid;
      logic [3:0] press;
      if (rst) begin
         m_lives    = 0;
         m_level    = 0;
         m_score    = 0;
         m_valid    = 1'b0;
         move_q.delete();
         m_vs_prev  = 1'b0;
         m_btn_prev = 4'd0;
         model_enter(0);
      end else begin
         tck        = m_vs_prev && !vsync;
         m_vs_prev  = vsync;
         press      = btn & ~m_btn_prev;
         m_btn_prev = btn;
         if (tck) m_ticks++;
         case (m_state)
            0, 4: begin
               if (tck) begin
                  if (btn == 4'hF) begin
                     m_cnt++;
                     if (m_cnt == START_HOLD) begin
                        m_lives = INIT_L;
                        m_level = 1;
                        m_score = 0;
                        model_enter(1);
                     end
                  end else begin
                     m_cnt = 0;
                  end
               end
            end
            1: begin
               was_valid = m_valid;
               if (m_valid && ready) m_valid = 1'b0;
               if (hit || goal) begin
                  if (m_valid) begin
                     void'(move_q.pop_back());
                     m_valid = 1'b0;
                  end
                  if (hit) begin
                     m_lives--;
                     model_enter(2);
                  end else begin
                     m_score = (m_score < 99) ? m_score + 1 : 99;
                     m_level = (m_level < MAX_L) ? m_level + 1 : MAX_L;
                     model_enter(3);
                  end
               end else if (!was_valid && press != 4'd0) begin
                  m_valid = 1'b1;
                  move_q.push_back(first_dir(press));
               end
            end
            2: begin
               if (tck) begin
                  m_cnt++;
                  if (m_cnt == DEATH_F) model_enter((m_lives == 0) ? 4 : 1);
               end
            end
            default: begin
               if (tck) begin
                  m_cnt++;
                  if (m_cnt == LEVEL_F) model_enter(1);
               end
            end
         endcase
      end
   endtask

   task automatic run_cycle();
      vsync = ((cyc % 4) < 2);
      @(posedge clk);
      model_step();
      #1;
      cyc++;
   endtask

   task automatic run_ticks(input int n);
      int target;
      target = m_ticks + n;
      while (m_ticks < target) run_cycle();
   endtask

   // Random switches/handshake; hit and goal only outside PLAY (must be ignored).
   task automatic run_noise(input int n);
      for (int i = 0; i < n; i++) begin
         btn   = 4'($urandom_range(0, 15));
         ready = ($urandom_range(0, 3) == 0);
         if (m_state == 1) begin
            hit  = 1'b0;
            goal = 1'b0;
         end else begin
            hit  = ($urandom_range(0, 7) == 0);
            goal = ($urandom_range(0, 7) == 0);
         end
         run_cycle();
      end
      hit  = 1'b0;
      goal = 1'b0;
   endtask

   task automatic pulse_event(input logic h, input logic g);
      hit  = h;
      goal = g;
      run_cycle();
      hit  = 1'b0;
      goal = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},   o_state, 0);
      check({tag, "_valid"},   o_move_valid, 0);
      check({tag, "_dir"},     o_move_dir, 0);
      check({tag, "_respawn"}, o_respawn, 0);
      check({tag, "_freeze"},  o_freeze, 1);
      check({tag, "_lives"},   o_lives, 0);
      check({tag, "_level"},   o_level, 0);
      check({tag, "_score"},   o_tens * 10 + o_ones, 0);
   endtask

   // Monitor: compares state entries and move acceptances as they appear.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_state != prev_state) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_state: got %0d, expected no change from %0d (t=%0t)",
                        o_state, prev_state, $time);
            end else begin
               entry_t e;
               e = exp_q.pop_front();
               check("entry_state",   o_state, e.state);
               check("entry_delay",   int'($time - e.t), 5);
               check("entry_lives",   o_lives, (1 << e.lives) - 1);
               check("entry_level",   o_level, e.level);
               check("entry_tens",    o_tens, e.score / 10);
               check("entry_ones",    o_ones, e.score % 10);
               check("entry_freeze",  o_freeze, (e.state != 1) ? 1 : 0);
               check("entry_respawn", o_respawn, (e.state == 1) ? 1 : 0);
               check("entry_valid",   o_move_valid, 0);
            end
         end else if (o_respawn) begin
            check("respawn_stray", o_respawn, 0);
         end

         if (o_move_valid && !prev_valid) begin
            vectors++;
            if (move_q.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_valid: got valid=1, expected 0 (t=%0t)", $time);
            end
         end

         if (o_move_valid && ready && !rst) begin
            if (move_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_without_request: got valid=1 dir=%0d, expected valid=0 (t=%0t)",
                        o_move_dir, $time);
            end else begin
               check("move_dir", o_move_dir, move_q.pop_front());
            end
         end

         prev_state = o_state;
         prev_valid = o_move_valid;
      end
   end

   initial begin
      rst   = 1'b1;
      vsync = 1'b0;
      btn   = 4'd0;
      hit   = 1'b0;
      goal  = 1'b0;
      ready = 1'b0;
      repeat (3) run_cycle();
      rst = 1'b0;
      check_reset_values("reset");
      prev_state = o_state;
      prev_valid = o_move_valid;
      mon_en     = 1'b1;

      // Start chord: 29 ticks is not enough, 30 starts the game.
      btn = 4'hF;
      run_ticks(START_HOLD - 1);
      btn = 4'h0;
      run_ticks(3);
      check("idle_after_29", o_state, 0);
      btn = 4'hF;
      run_ticks(START_HOLD);
      check("play_after_30", o_state, 1);
      btn = 4'h0;
      repeat (3) run_cycle();

      // Handshake: Up held pending, Left dropped, Right dropped at acceptance.
      btn = 4'b0001;
      run_cycle();
      repeat (2) run_cycle();
      btn = 4'b0101;
      run_cycle();
      btn = 4'b0001;
      repeat (2) run_cycle();
      check("pending_valid", o_move_valid, 1);
      check("pending_dir", o_move_dir, 0);
      btn   = 4'b1001;
      ready = 1'b1;
      run_cycle();
      ready = 1'b0;
      run_cycle();
      check("valid_cleared", o_move_valid, 0);

      // Priority: Down and Right together resolve to Down.
      btn = 4'b0000;
      repeat (2) run_cycle();
      btn = 4'b1010;
      run_cycle();
      check("priority_dir", o_move_dir, 1);
      ready = 1'b1;
      run_cycle();
      ready = 1'b0;
      btn   = 4'b0000;
      run_cycle();

      // Random move traffic in PLAY.
      run_noise(400);

      // Goals: score climbs through 09->10 and saturates at 99; level at 7.
      for (int g = 0; g < 101; g++) begin
         run_noise(12);
         pulse_event(1'b0, 1'b1);
         run_noise((LEVEL_F + 2) * 4);
      end
      check("score_sat", o_tens * 10 + o_ones, 99);
      check("level_sat", o_level, MAX_L);

      // Hit and goal together: hit wins, then three deaths to GAME_OVER.
      pulse_event(1'b1, 1'b1);
      run_noise((DEATH_F + 2) * 4);
      pulse_event(1'b1, 1'b0);
      run_noise((DEATH_F + 2) * 4);
      pulse_event(1'b1, 1'b0);
      run_noise((DEATH_F + 2) * 4);
      check("game_over", o_state, 4);
      check("game_over_lives", o_lives, 0);
      check("game_over_freeze", o_freeze, 1);

      // Restart from GAME_OVER, then reset in the middle of DYING.
      btn = 4'hF;
      run_ticks(START_HOLD + 1);
      btn = 4'h0;
      run_noise(40);
      pulse_event(1'b1, 1'b0);
      run_noise(80);
      rst = 1'b1;
      run_cycle();
      check_reset_values("mid_dying_reset");
      rst = 1'b0;
      btn = 4'h0;
      repeat (4) run_cycle();

      check("pending_entries", exp_q.size(), 0);
      check("final_state", o_state, m_state);
      check("final_valid", o_move_valid, m_valid ? 1 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/frogger_game_ctrl.md
Name: frogger_game_ctrl

Overview:
Game-level sequencer for Frogger; sits between the switch debouncer and the game datapath/VGA renderer. Turns debounced switch levels into one-shot move requests via a valid/ready handshake, detects the start chord, and sequences IDLE/PLAY/DYING/LEVEL_UP/GAME_OVER. Owns lives, level and BCD score, which drive the LEDs and seven-segment decoders. All timing is in frames, derived from VSync.

Parameters:
START_HOLD_FRAMES, 30, frames all four switches must be held to start
DEATH_FRAMES, 60, freeze length after a hit
LEVEL_FRAMES, 90, freeze length after reaching goal
INIT_LIVES, 3, lives loaded at game start (1..3)
MAX_LEVEL, 7, level saturation value

Ports:
i_Clk  in  1  system/pixel clock
i_Rst  in  1  synchronous reset, active-high
i_VSync  in  1  VSync from VGA sync pulses (high during active rows)
i_Buttons  in  4  debounced switches {Right,Left,Down,Up}, active-high
i_Hit  in  1  collision pulse/level from game datapath
i_Goal  in  1  frog reached home row
i_Move_Ready  in  1  datapath accepts move this cycle
o_Move_Valid  out  1  move request pending
o_Move_Dir  out  2  0=Up 1=Down 2=Left 3=Right
o_Frog_Respawn  out  1  one-cycle pulse: place frog at start
o_Freeze  out  1  datapath must halt object motion
o_State  out  3  current state code
o_Lives  out  3  thermometer lives for LEDs
o_Level  out  3  current level (speed select)
o_Score_Tens  out  4  BCD tens
o_Score_Ones  out  4  BCD ones

Behaviour:
- Clocking: single clock i_Clk; reset synchronous, active-high on i_Rst. Reset overrides everything, including mid-freeze or mid-handshake.
- Reset values: State=IDLE(0), Move_Valid=0, Move_Dir=0, Respawn=0, Freeze=1, Lives=0, Level=0, Score=00. All internal counters and edge registers are cleared.
- Frame tick: registered i_VSync; tick = 1 for one cycle on the 1→0 edge.
- Button edges: registered i_Buttons; press = rising edge per bit.
- States: IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4.
- IDLE/GAME_OVER:
  - Hold counter increments on each tick while i_Buttons==4'hF; cleared on any tick where it is not 4'hF.
  - When the count reaches START_HOLD_FRAMES → PLAY: Lives=INIT_LIVES, Level=1, Score=00, Respawn pulse in the transition cycle, Freeze=0.
  - Move requests are never raised in these states.
- PLAY, moves:
  - On a press while Move_Valid=0, latch direction and set Move_Valid the next cycle.
  - Simultaneous presses resolve with priority Up>Down>Left>Right.
  - Presses while Move_Valid=1 are dropped.
  - Move_Valid and Move_Dir hold stable until i_Move_Ready=1, then Move_Valid clears the cycle after acceptance.
  - A press in the same cycle as acceptance is dropped.
  - While 4'hF is held, press edges are still arbitrated normally.
- PLAY, hit/goal:
  - i_Hit=1 → DYING: Freeze=1; Lives decrements once; pending move is cancelled (Move_Valid=0).
  - i_Goal=1 (with i_Hit=0) → LEVEL_UP: Freeze=1; Score +1 BCD (ones 9→0 carries into tens; 99 saturates); Level +1 saturating at MAX_LEVEL; pending move cancelled.
  - i_Hit and i_Goal in the same cycle: the hit wins.
  - i_Hit and i_Goal are ignored in all other states.
- DYING: count DEATH_FRAMES ticks. Then:
  - If Lives==0 → GAME_OVER (Freeze stays 1).
  - Otherwise → PLAY with a Respawn pulse and Freeze=0.
- LEVEL_UP: count LEVEL_FRAMES ticks, then → PLAY with a Respawn pulse and Freeze=0.
- Freeze=1 in every state except PLAY.
- Respawn is exactly one cycle wide, in the cycle the state register becomes PLAY.
- o_Lives: 0→000, 1→001, 2→011, 3→111.
- Frame counter: 7 bits, cleared on every state entry.

Decomposition:
- Shared package frogger_pkg:
  - state encodings
  - direction codes
  - BCD digit typedef
- One sub-module, frogger_frame_tick: VSync edge detector producing the tick.
- Arbitration, FSM and score stay in frogger_game_ctrl.

Test Plan:
- Start chord: hold 4'hF for 29 ticks, then release. → State stays IDLE. Hold 30 ticks → State=1, Lives=3'b111, Level=1, Score=00, one Respawn pulse.
- Handshake: press Up with i_Move_Ready=0 for 5 cycles → Valid=1, Dir=0 stable throughout. Press Left meanwhile → dropped. Ready=1 → Valid=0 next cycle.
- Priority: Down and Right pressed in the same cycle → Dir=1.
- Death sequence: three i_Hit pulses, each followed by 60 ticks.
  - After the first: Lives=011, then Respawn; after the second: 001, then Respawn.
  - After the third: GAME_OVER, Lives=000, Freeze=1.
- Scoring: 10 goals from score 09 start → after the first goal Tens=1, Ones=0. From 99, a goal holds at 99. Level saturates at 7.
- Hit and Goal in the same cycle → DYING and score unchanged. i_Rst asserted mid-DYING → IDLE with all reset values the next cycle.
